// File: rtl/led_inten_ctrl_pkg.sv
// led_pkg: shared types and constants for the LED intensity datapath
package led_pkg;
  typedef enum logic [2:0] {IDLE, SQ_L, SQ_R, SQRT, DONE} state_t;
  localparam int NUM_LEDS = 8;
  localparam int SQRT_ITERS = 16;
  typedef logic signed [15:0] sample_t;
  typedef logic [15:0] inten_t;
endpackage

// File: rtl/led_inten_ctrl_if.sv
// led_inten_ctrl_if: sample stream in, intensity/LED results out
interface led_inten_ctrl_if;
  import led_pkg::*;
  logic vld;
  sample_t lft_chnnl;
  sample_t rght_chnnl;
  inten_t inten;
  logic inten_vld;
  logic busy;
  logic ovrn;
  logic [NUM_LEDS-1:0] LED;
  modport master(output vld, lft_chnnl, rght_chnnl, input inten, inten_vld, busy, ovrn, LED);
  modport slave(input vld, lft_chnnl, rght_chnnl, output inten, inten_vld, busy, ovrn, LED);
endinterface

// File: rtl/led_inten_ctrl_isqrt_serial.sv
// isqrt_serial: restoring digit-by-digit square root, one root bit per cycle
module isqrt_serial
  import led_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] radicand,
  output logic        done,
  output inten_t      root
);
  logic run;
  logic [3:0] cnt;
  logic [31:0] a;
  logic [17:0] rem;
  inten_t q;
  logic [19:0] rs, d;
  logic ge;
  // trial subtraction; root is the final value in the done cycle
  always_comb begin
    rs = {rem, a[31:30]};
    d = {2'b00, q, 2'b01};
    ge = rs >= d;
    done = run && cnt == 4'(SQRT_ITERS - 1);
    root = {q[14:0], ge};
  end
  // iteration registers; start is ignored while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      a <= '0;
      rem <= '0;
      q <= '0;
    end else if (start && !run) begin
      run <= 1'b1;
      cnt <= '0;
      a <= radicand;
      rem <= '0;
      q <= '0;
    end else if (run) begin
      a <= a << 2;
      rem <= ge ? 18'(rs - d) : rs[17:0];
      q <= {q[14:0], ge};
      cnt <= cnt + 4'd1;
      run <= !done;
    end
  end
endmodule

// File: rtl/led_inten_ctrl.sv
// led_inten_ctrl: stereo RMS intensity with peak-hold/decay LED bar
module led_inten_ctrl
  import led_pkg::*;
#(
  parameter int DECAY_DIV = 1024,
  parameter logic [15:0] STEP = 16'h0200
) (
  input logic clk,
  input logic rst,
  led_inten_ctrl_if.slave bus
);
  localparam int CW = $clog2(DECAY_DIV + 1);
  state_t st, nst;
  sample_t l_q, r_q, m;
  logic signed [31:0] p;
  logic [31:0] sum, sum_n;
  inten_t inten, peak, root;
  logic [CW-1:0] cnt;
  logic acc, busy, sq_done;
  logic [NUM_LEDS-1:0] led;
  logic [16:0] thr;
  // one shared squarer selected by state, next-state and status outputs
  always_comb begin
    busy = st == SQ_L || st == SQ_R || st == SQRT;
    acc = bus.vld && (st == IDLE || st == DONE);
    m = st == SQ_L ? l_q : r_q;
    p = m * m;
    sum_n = (st == SQ_L ? 32'd0 : sum) + $unsigned(p);
    nst = acc ? SQ_L : st == SQ_L ? SQ_R : st == SQ_R ? SQRT :
          st == SQRT ? (sq_done ? DONE : SQRT) : IDLE;
    bus.busy = busy;
    bus.ovrn = busy && bus.vld;
    bus.inten_vld = st == DONE;
    bus.inten = inten;
  end
  // LED thresholds built by accumulation so no second multiplier appears
  always_comb begin
    led = '0;
    thr = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led[i] = {1'b0, peak} > thr;
      thr = thr + {1'b0, STEP};
    end
    bus.LED = led;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nst;
  end
  // sample latch, sum of squares, result and peak-hold/decay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q <= '0;
      r_q <= '0;
      sum <= '0;
      inten <= '0;
      peak <= '0;
      cnt <= '0;
    end else begin
      if (acc) begin
        l_q <= bus.lft_chnnl;
        r_q <= bus.rght_chnnl;
      end
      if (st == SQ_L || st == SQ_R) sum <= sum_n;
      if (st == SQRT && sq_done) inten <= root;
      if (st == DONE) begin
        if (inten > peak) begin
          peak <= inten;
          cnt <= '0;
        end else if (cnt == CW'(DECAY_DIV - 1)) begin
          peak <= peak > STEP ? peak - STEP : 16'd0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  isqrt_serial u_sqrt (
    .clk(clk),
    .rst(rst),
    .start(st == SQ_R),
    .radicand(sum_n >> 1),
    .done(sq_done),
    .root(root)
  );
endmodule

// File: tb/tb_led_inten_ctrl.sv
// tb_led_inten_ctrl: scoreboard bench with a timing/arithmetic reference model
module tb_led_inten_ctrl;
  import led_pkg::*;
  localparam int DD = 4;
  localparam int STEP = 16'h0200;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  led_inten_ctrl_if bus();
  led_inten_ctrl #(.DECAY_DIV(DD), .STEP(16'h0200)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int val; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, pass = 0, total = 0, last_acc = -1000, mpeak = 0, mcnt = 0;
  logic exp_ovrn = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  function automatic int root_of(input int l, input int r);
    longint mn, s;
    mn = (longint'(l) * l + longint'(r) * r) / 2;
    s = longint'($sqrt(real'(mn)));
    while (s * s > mn) s--;
    while ((s + 1) * (s + 1) <= mn) s++;
    return int'(s);
  endfunction
  function automatic int led_of(input int pk);
    int v = 0;
    for (int i = 0; i < 8; i++) if (pk > i * STEP) v |= (1 << i);
    return v;
  endfunction
  task automatic cycle_in(input logic v, input int l, input int r);
    int e;
    exp_t x;
    @(posedge clk);
    #1;
    bus.vld = v;
    bus.lft_chnnl = 16'(l);
    bus.rght_chnnl = 16'(r);
    exp_ovrn = 0;
    if (v) begin
      e = cyc + 1;
      if (e - last_acc >= 19) begin
        last_acc = e;
        x.val = root_of(l, r);
        x.due = e + 18;
        q.push_back(x);
      end else exp_ovrn = 1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) cycle_in(0, 0, 0);
  endtask
  task automatic run_for(input int l, input int r);
    cycle_in(1, l, r);
    idle(20);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1;
    bus.vld = 0;
    exp_ovrn = 0;
    q.delete();
    mpeak = 0;
    mcnt = 0;
    last_acc = -1000;
    #1;
    chk("rst_inten", int'(bus.inten), 0);
    chk("rst_led", int'(bus.LED), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_vld", int'(bus.inten_vld), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask
  function automatic int rnd_s();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    chk("ovrn", int'(bus.ovrn), int'(exp_ovrn));
    chk("led", int'(bus.LED), led_of(mpeak));
    chk("busy", int'(bus.busy), int'(cyc >= last_acc && cyc - last_acc <= 17));
    if (bus.inten_vld) begin
      if (q.size() == 0) chk("inten_vld_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("inten", int'(bus.inten), e.val);
        chk("latency", cyc, e.due);
        if (e.val > mpeak) begin
          mpeak = e.val;
          mcnt = 0;
        end else if (++mcnt == DD) begin
          mpeak = mpeak > STEP ? mpeak - STEP : 0;
          mcnt = 0;
        end
      end
    end
  end
  initial begin
    bus.vld = 0;
    bus.lft_chnnl = 0;
    bus.rght_chnnl = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_inten", int'(bus.inten), 0);
    chk("init_led", int'(bus.LED), 0);
    chk("init_busy", int'(bus.busy), 0);
    chk("init_vld", int'(bus.inten_vld), 0);
    #1 rst = 0;
    run_for(0, 0);
    chk("t1_inten", int'(bus.inten), 0);
    chk("t1_led", int'(bus.LED), 8'h00);
    run_for(3, 4);
    chk("t2_inten", int'(bus.inten), 3);
    chk("t2_led", int'(bus.LED), 8'h01);
    run_for(3000, 3000);
    chk("t3_inten", int'(bus.inten), 16'h0BB8);
    chk("t3_led", int'(bus.LED), 8'h3F);
    run_for(-32768, -32768);
    chk("t3_max_inten", int'(bus.inten), 16'h8000);
    chk("t3_max_led", int'(bus.LED), 8'hFF);
    cycle_in(1, 1000, -2000);
    idle(4);
    cycle_in(1, 7, 7);
    idle(20);
    chk("t4_inten", int'(bus.inten), root_of(1000, -2000));
    for (int i = 0; i < 60; i++) cycle_in(1, rnd_s(), rnd_s());
    idle(20);
    do_reset();
    run_for(3000, 3000);
    repeat (4) run_for(0, 0);
    chk("t5_led_1f", int'(bus.LED), 8'h1F);
    repeat (24) run_for(0, 0);
    chk("t5_led_00", int'(bus.LED), 8'h00);
    run_for(3000, 3000);
    cycle_in(1, 123, 456);
    idle(8);
    do_reset();
    run_for(100, -200);
    chk("t6_inten", int'(bus.inten), root_of(100, -200));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) cycle_in(1, rnd_s(), rnd_s());
      else cycle_in(0, 0, 0);
    end
    idle(1);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
